pipe_skid16: RTL and testbench

- Consumer-side 16-bit pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Sits between a producing datapath stage and a consuming stage that may stall.
- Registers data so that neither the ready path nor the data path is combinational from input to output.
- Lets the downstream stall without dropping the word already in flight.

---
 rtl/pipe_skid16.sv | 101 ++++++++++
 tb/tb_pipe_skid16.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid16.sv
// Valid/ready pipeline stage with a 2-entry skid buffer; outputs decode from registered state only.
// Optional synchronous flush port enabled by defining PIPE_SKID16_FLUSH_EN.
module pipe_skid16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nClear,
`ifdef PIPE_SKID16_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  // state | meaning
  // EMPTY | no word held, main is stale
  // ONE   | head word in main, skid unused
  // TWO   | head in main, next word in skid, upstream stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    case (state_q)
      EMPTY:   count = 2'd0;
      ONE:     count = 2'd1;
      TWO:     count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef PIPE_SKID16_FLUSH_EN
    // Flush drops any handshake of this cycle but leaves storage untouched.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!nClear) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid16.sv
// Self-checking bench for pipe_skid16: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_skid16;

  logic        clk = 1'b0;
  logic        nClear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [1:0]  count;
`ifdef PIPE_SKID16_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  logic [15:0] last_main;

  always #5 clk = ~clk;

  pipe_skid16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .nClear    (nClear),
`ifdef PIPE_SKID16_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // Model: a FIFO of at most two words; the head is what the consumer sees.
  task automatic tick();
    bit flushing = 1'b0;
`ifdef PIPE_SKID16_FLUSH_EN
    flushing = flush;
`endif
    if (!nClear) begin
      q.delete();
      last_main = 16'h0000;
    end else if (flushing) begin
      q.delete();
    end else begin
      bit can_take = (q.size() < 2);
      bit pop      = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (in_valid && can_take) q.push_back(in_data);
    end
    if (q.size() > 0) last_main = q[0];
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] exp_vec();
    int sz = q.size();
    logic [1:0] c = 2'(sz);
    return {sz != 0, sz != 2, c, (sz != 0) ? q[0] : last_main};
  endfunction

  task automatic test_reset();
    nClear = 1'b0; in_valid = 1'b1; in_data = 16'hABCD; out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, in_ready, count, out_data} !== {1'b0, 1'b1, 2'd0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_hold got v=%0b r=%0b c=%0d d=%h want v=0 r=1 c=0 d=0000",
               out_valid, in_ready, count, out_data);
    end
    nClear = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_release got v=%0b r=%0b c=%0d want v=0 r=1 c=0", out_valid, in_ready, count);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, count, out_data} !== {1'b1, 2'd1, 16'h1234}) begin
      failures++;
      $display("FAIL single_present got v=%0b c=%0d d=%h want v=1 c=1 d=1234", out_valid, count, out_data);
    end
    tick();
    checks++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL single_drain got v=%0b r=%0b c=%0d want v=0 r=1 c=0", out_valid, in_ready, count);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
      checks++;
      if ({out_valid, in_ready, count, out_data} !== {1'b1, 1'b1, 2'd1, 16'(i)}) begin
        failures++;
        $display("FAIL stream_%0d got v=%0b r=%0b c=%0d d=%h want v=1 r=1 c=1 d=%h",
                 i, out_valid, in_ready, count, out_data, 16'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL stream_end got v=%0b c=%0d want v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    checks++;
    if ({in_ready, count, out_data} !== {1'b0, 2'd2, 16'h0011}) begin
      failures++;
      $display("FAIL skid_full got r=%0b c=%0d d=%h want r=0 c=2 d=0011", in_ready, count, out_data);
    end
    in_data = 16'h0033;
    tick();
    checks++;
    if ({in_ready, count, out_data} !== {1'b0, 2'd2, 16'h0011}) begin
      failures++;
      $display("FAIL skid_blocked got r=%0b c=%0d d=%h want r=0 c=2 d=0011", in_ready, count, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready, count, out_data} !== {1'b1, 1'b1, 2'd1, 16'h0022}) begin
      failures++;
      $display("FAIL skid_pop1 got v=%0b r=%0b c=%0d d=%h want v=1 r=1 c=1 d=0022",
               out_valid, in_ready, count, out_data);
    end
    tick();
    checks++;
    if ({out_valid, count, out_data} !== {1'b0, 2'd0, 16'h0022}) begin
      failures++;
      $display("FAIL skid_pop2 got v=%0b c=%0d d=%h want v=0 c=0 d=0022 (0033 must not appear)",
               out_valid, count, out_data);
    end
  endtask

  task automatic test_simul();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00AA;
    tick();
    in_data = 16'h00BB; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, count, out_data} !== {1'b1, 2'd1, 16'h00BB}) begin
      failures++;
      $display("FAIL simul_push_pop got v=%0b c=%0d d=%h want v=1 c=1 d=00BB", out_valid, count, out_data);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0101;
    tick();
    in_data = 16'h0202;
    tick();
    nClear = 1'b0; in_data = 16'h5555; out_ready = 1'b1;
    tick();
    nClear = 1'b1; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, count, out_data} !== {1'b0, 1'b1, 2'd0, 16'h0000}) begin
      failures++;
      $display("FAIL mid_reset got v=%0b r=%0b c=%0d d=%h want v=0 r=1 c=0 d=0000",
               out_valid, in_ready, count, out_data);
    end
    tick();
    checks++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL mid_reset_after got v=%0b c=%0d want v=0 c=0", out_valid, count);
    end
  endtask

`ifdef PIPE_SKID16_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0707;
    tick();
    in_data = 16'h0808;
    tick();
    flush = 1'b1; in_data = 16'h0909; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, count, out_data} !== {1'b0, 1'b1, 2'd0, 16'h0707}) begin
      failures++;
      $display("FAIL flush got v=%0b r=%0b c=%0d d=%h want v=0 r=1 c=0 d=0707",
               out_valid, in_ready, count, out_data);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      nClear    = ($urandom_range(0, 49) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 16'($urandom);
`ifdef PIPE_SKID16_FLUSH_EN
      flush     = ($urandom_range(0, 39) == 0);
`endif
      tick();
      checks++;
      if ({out_valid, in_ready, count, out_data} !== exp_vec()) begin
        failures++;
        $display("FAIL random_%0d got v=%0b r=%0b c=%0d d=%h want {v,r,c,d}=%h",
                 i, out_valid, in_ready, count, out_data, exp_vec());
      end
    end
    nClear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
`ifdef PIPE_SKID16_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
  endtask

  initial begin
    last_main = 16'h0000;
    test_reset();
    test_single();
    test_stream();
    test_stall_skid();
    test_simul();
    test_mid_reset();
`ifdef PIPE_SKID16_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
